// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared constants and elaboration helpers for the FIFO family
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 4;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  function automatic bit thresholds_ok(input int aw, input int af_lvl, input int ae_lvl);
    return (aw >= 1) &&
           (af_lvl >= 1) && (af_lvl <= (1 << aw)) &&
           (ae_lvl >= 0) && (ae_lvl <= (1 << aw) - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_regfile.sv
// ============================================================================
// fifo_regfile : 2^AW x DW storage, synchronous write, asynchronous read
// Revision     : 1.0
// ============================================================================
`default_nettype none

module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int DEPTH = 1 << AW;

  // Contents are never reset; the pointers alone define what is valid.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/generic_fifo_sc_lvl.sv
// ============================================================================
// generic_fifo_sc_lvl : single-clock FIFO with level, thresholds, FWFT option
// Revision            : 1.0
// ============================================================================
`default_nettype none

module generic_fifo_sc_lvl
  import fifo_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 4,
  parameter int FWFT   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW:0] AF_THR = (AW + 1)'(AF_LVL);
  localparam logic [AW:0] AE_THR = (AW + 1)'(AE_LVL);

  if (!thresholds_ok(AW, AF_LVL, AE_LVL) || (DW < 1)) begin : g_bad_params
    $error("generic_fifo_sc_lvl: illegal DW/AW/AF_LVL/AE_LVL combination");
  end

  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] rd_data;

  // One extra pointer bit disambiguates full from empty; level never
  // exceeds 2^AW, so its MSB alone marks full.
  assign level        = wp - rp;
  assign empty        = (wp == rp);
  assign full         = level[AW];
  assign almost_full  = (level >= AF_THR);
  assign almost_empty = (level <= AE_THR);

  assign wr_en = we & ~full  & ~clr;
  assign rd_en = re & ~empty & ~clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      if (we && full)  ovf <= 1'b1;
      if (re && empty) udf <= 1'b1;
    end
  end

  fifo_regfile #(
    .DW (DW),
    .AW (AW)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wp[AW-1:0]),
    .wr_data (din),
    .rd_addr (rp[AW-1:0]),
    .rd_data (rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    assign dout = rd_data;
  end else begin : g_std
    logic [DW-1:0] dout_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       dout_q <= '0;
      else if (rd_en) dout_q <= rd_data;
    end

    assign dout = dout_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_generic_fifo_sc_lvl.sv
// ============================================================================
// tb_generic_fifo_sc_lvl : standard and FWFT FIFOs driven in lockstep vs a queue model
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_generic_fifo_sc_lvl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       we  = 1'b0;
  logic       re  = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] level0, level1;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of stored words plus sticky bits.
  logic [7:0] q[$];
  bit         m_ovf, m_udf;
  logic [7:0] m_dout0;

  typedef struct {
    logic       we, re, clr;
    logic [7:0] din;
    int         lvl;
    logic       full, empty, af, ae, ovf, udf;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  generic_fifo_sc_lvl #(.DW(8), .AW(4), .AF_LVL(12), .AE_LVL(4), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .level(level0), .ovf(ovf0), .udf(udf0)
  );

  generic_fifo_sc_lvl #(.DW(8), .AW(4), .AF_LVL(12), .AE_LVL(4), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .level(level1), .ovf(ovf1), .udf(udf1)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic check_model();
    int n;
    n = q.size();
    chk("level0", 32'(level0), 32'(n));
    chk("level1", 32'(level1), 32'(n));
    chk("full0",  32'(full0),  32'(n == 16));
    chk("full1",  32'(full1),  32'(n == 16));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("af0",    32'(af0),    32'(n >= 12));
    chk("af1",    32'(af1),    32'(n >= 12));
    chk("ae0",    32'(ae0),    32'(n <= 4));
    chk("ae1",    32'(ae1),    32'(n <= 4));
    chk("ovf0",   32'(ovf0),   32'(m_ovf));
    chk("ovf1",   32'(ovf1),   32'(m_ovf));
    chk("udf0",   32'(udf0),   32'(m_udf));
    chk("udf1",   32'(udf1),   32'(m_udf));
    chk("dout0",  32'(dout0),  32'(m_dout0));
    if (n > 0) chk("dout1_head", 32'(dout1), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    bit was_full, was_empty;
    @(negedge clk);
    we = w; re = r; clr = c; din = d;
    @(posedge clk);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      if (r) begin
        if (was_empty) m_udf = 1'b1;
        else           m_dout0 = q.pop_front();
      end
      if (w) begin
        if (was_full) m_ovf = 1'b1;
        else          q.push_back(d);
      end
    end
    #1 check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_level0"}, 32'(level0), 32'd0);
    chk({tag, "_level1"}, 32'(level1), 32'd0);
    chk({tag, "_empty0"}, 32'(empty0), 32'd1);
    chk({tag, "_full0"},  32'(full0),  32'd0);
    chk({tag, "_ae0"},    32'(ae0),    32'd1);
    chk({tag, "_af0"},    32'(af0),    32'd0);
    chk({tag, "_ovf0"},   32'(ovf0),   32'd0);
    chk({tag, "_udf0"},   32'(udf0),   32'd0);
    chk({tag, "_dout0"},  32'(dout0),  32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_dout0 = 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;

    // {we, re, clr, din, level, full, empty, af, ae, ovf, udf, dout0}
    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h77, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 8'h22, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22};

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].clr, tbl[i].din);
      chk($sformatf("tbl%0d_level", i), 32'(level0), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_full", i),  32'(full0),  32'(tbl[i].full));
      chk($sformatf("tbl%0d_empty", i), 32'(empty0), 32'(tbl[i].empty));
      chk($sformatf("tbl%0d_af", i),    32'(af0),    32'(tbl[i].af));
      chk($sformatf("tbl%0d_ae", i),    32'(ae0),    32'(tbl[i].ae));
      chk($sformatf("tbl%0d_ovf", i),   32'(ovf0),   32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_udf", i),   32'(udf0),   32'(tbl[i].udf));
      chk($sformatf("tbl%0d_dout", i),  32'(dout0),  32'(tbl[i].dout));
    end

    // Fill to full; threshold edges are checked on every step by the model.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'($urandom));
      if (i == 4)  chk("ae_drop_at_5",  32'(ae0), 32'd0);
      if (i == 10) chk("af_low_at_11",  32'(af0), 32'd0);
      if (i == 11) chk("af_rise_at_12", 32'(af0), 32'd1);
    end
    chk("full_after_16", 32'(full0), 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("ovf_17th", 32'(ovf0), 32'd1);
    chk("lvl_17th", 32'(level0), 32'd16);
    step(1'b1, 1'b1, 1'b0, 8'hDD);
    chk("rw_at_full_lvl", 32'(level0), 32'd15);

    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drained_empty", 32'(empty0), 32'd1);
    step(1'b1, 1'b1, 1'b0, 8'h3C);
    chk("rw_at_empty_lvl", 32'(level0), 32'd1);
    chk("udf_sticky", 32'(udf0), 32'd1);
    chk("ovf_sticky", 32'(ovf0), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Mid-operation asynchronous reset at level 7.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'($urandom));
    chk("pre_rst_level", 32'(level0), 32'd7);
    we = 1'b0; re = 1'b0; clr = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h5A);
    chk("first_wr_after_rst", 32'(level0), 32'd1);

    // Clear with a concurrent write at level 7.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    chk("pre_clr_level", 32'(level0), 32'd7);
    step(1'b1, 1'b0, 1'b1, 8'h99);
    chk("clr_wins_level", 32'(level0), 32'd0);
    chk("clr_wins_empty", 32'(empty0), 32'd1);

    // FWFT stream: 3-word prefill then 100 simultaneous read/write cycles.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'($urandom));
      if (level1 !== 5'd3) chk("stream_level1", 32'(level1), 32'd3);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Random traffic with occasional clear.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 2), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
